// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output imm_src, alu_src_a, alu_src_b, alu_control, result_src,
    output adr_src, ir_write, pc_write, reg_write, mem_write
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  imm_src, alu_src_a, alu_src_b, alu_control, result_src,
    input  adr_src, ir_write, pc_write, reg_write, mem_write
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM; outputs combinational from state, memory states stall on mem_ready.
// Optional ILLEGAL_TRAP_EN: unsupported opcodes park the FSM in a sticky TRAP state flagged on illegal_instr.
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              illegal_instr
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q;
  state_t     state_d;
  logic       ready;
  logic [1:0] aluop;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       trap_flag;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    aluop      = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    trap_flag  = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
        state_d    = ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Speculatively form the branch target in ALUOut while decoding.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_B:         state_d = BRANCH;
          OP_JAL:       state_d = JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        // funct3[0] distinguishes bne from beq, so it inverts the taken sense.
        alu_src_a = 2'b10;
        aluop     = 2'b01;
        pc_write  = bus.zero ^ bus.funct3[0];
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        trap_flag = 1'b1;
        state_d   = TRAP;
      end
`endif
      default: begin
        state_d = FETCH;
      end
    endcase
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      trap_flag = 1'b0;
    end
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.imm_src = 2'b01;
      OP_B:    bus.imm_src = 2'b10;
      OP_JAL:  bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

  always_comb begin
    case (aluop)
      2'b00: bus.alu_control = 3'b000;
      2'b01: bus.alu_control = 3'b001;
      default: begin
        case (bus.funct3)
          // Only register-register ops honour funct7b5; addi with imm[10]=1 stays an add.
          3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_control = 3'b101;
          3'b110:  bus.alu_control = 3'b011;
          3'b111:  bus.alu_control = 3'b010;
          default: bus.alu_control = 3'b000;
        endcase
      end
    endcase
  end

  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.result_src = result_src;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.mem_write  = mem_write;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = trap_flag;
`else
  logic unused_trap;
  assign unused_trap = trap_flag;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table plus stall and illegal-op sequences.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [1:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [1:0] rs;
    logic       adr;
    logic       ir;
    logic       pc;
    logic       rw;
    logic       mw;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       rdy;
    logic       rst;
    logic       en_only;
    out_t       exp;
  } vec_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b1;
  logic reset;
  multicycle_ctrl_if bus();
`ifdef ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  vec_t tbl[$];
  vec_t sb[$];

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  function automatic out_t o(input logic [1:0] imm, input logic [1:0] a, input logic [1:0] b,
                             input logic [2:0] alu, input logic [1:0] rs, input logic adr,
                             input logic ir, input logic pc, input logic rw, input logic mw);
    out_t r;
    r = '{imm, a, b, alu, rs, adr, ir, pc, rw, mw};
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r = '{bus.imm_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.result_src,
          bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write};
    return r;
  endfunction

  task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input logic rdy, input logic rst, input out_t e);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
    v.rdy = rdy; v.rst = rst; v.en_only = 1'b0; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic rdy, input logic rst);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    bus.zero = z; bus.mem_ready = rdy; reset = rst;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    out_t got;
    int   stall;
    int   cycles;
    int   rw_cnt;
    int   adr_cnt;
    bit   done;

    // name, op, f3, f7, zero, ready, reset, {imm, a, b, alu, rs, adr, ir, pc, rw, mw}
    add("rst_0",    LW, 3'b000, 0, 0, 1, 1, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("rst_1",    LW, 3'b000, 0, 0, 1, 1, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0, 0, 0, 0));
    add("lw_fetch", LW, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("lw_dec",   LW, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("lw_madr",  LW, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("lw_mrd",   LW, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0));
    add("lw_wb",    LW, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0, 1, 0));
    add("sw_fetch", SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("sw_dec",   SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("sw_madr",  SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("sw_mwr",   SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    add("sub_f",    RT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("sub_d",    RT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("sub_ex",   RT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0));
    add("sub_wb",   RT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("or_f",     RT, 3'b110, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("or_d",     RT, 3'b110, 0, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("or_ex",    RT, 3'b110, 0, 0, 1, 0, o(2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 0, 0, 0, 0, 0));
    add("or_wb",    RT, 3'b110, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("slt_f",    RT, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("slt_d",    RT, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("slt_ex",   RT, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0, 0, 0, 0, 0));
    add("slt_wb",   RT, 3'b010, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("andi_f",   IT, 3'b111, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("andi_d",   IT, 3'b111, 0, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("andi_ex",  IT, 3'b111, 0, 0, 1, 0, o(2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 0, 0, 0, 0, 0));
    add("andi_wb",  IT, 3'b111, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("addi_f",   IT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("addi_d",   IT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("addi_ex",  IT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("addi_wb",  IT, 3'b000, 1, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("xori_f",   IT, 3'b100, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("xori_d",   IT, 3'b100, 0, 0, 1, 0, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("xori_ex",  IT, 3'b100, 0, 0, 1, 0, o(2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("xori_wb",  IT, 3'b100, 0, 0, 1, 0, o(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("beq1_f",   BR, 3'b000, 0, 1, 1, 0, o(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("beq1_d",   BR, 3'b000, 0, 1, 1, 0, o(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("beq1_br",  BR, 3'b000, 0, 1, 1, 0, o(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 1, 0, 0));
    add("beq0_f",   BR, 3'b000, 0, 0, 1, 0, o(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("beq0_d",   BR, 3'b000, 0, 0, 1, 0, o(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("beq0_br",  BR, 3'b000, 0, 0, 1, 0, o(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0));
    add("bne1_f",   BR, 3'b001, 0, 1, 1, 0, o(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("bne1_d",   BR, 3'b001, 0, 1, 1, 0, o(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("bne1_br",  BR, 3'b001, 0, 1, 1, 0, o(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0, 0, 0));
    add("bne0_f",   BR, 3'b001, 0, 0, 1, 0, o(2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("bne0_d",   BR, 3'b001, 0, 0, 1, 0, o(2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("bne0_br",  BR, 3'b001, 0, 0, 1, 0, o(2'b10, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 1, 0, 0));
    add("jal_f",    JL, 3'b000, 0, 0, 1, 0, o(2'b11, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("jal_d",    JL, 3'b000, 0, 0, 1, 0, o(2'b11, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("jal_j",    JL, 3'b000, 0, 0, 1, 0, o(2'b11, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0, 1, 0, 0));
    add("jal_wb",   JL, 3'b000, 0, 0, 1, 0, o(2'b11, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1, 0));
    add("sws_f0",   SW, 3'b010, 0, 0, 0, 0, o(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0, 0, 0, 0));
    add("sws_f1",   SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("sws_d",    SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("sws_madr", SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("sws_mw0",  SW, 3'b010, 0, 0, 0, 0, o(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    add("sws_mw1",  SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 1));
    add("swr_f",    SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    add("swr_d",    SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("swr_madr", SW, 3'b010, 0, 0, 1, 0, o(2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    add("swr_rst",  SW, 3'b010, 0, 0, 1, 1, o(2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0));
    tbl[0].en_only = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.op, v.f3, v.f7, v.z, v.rdy, v.rst);
      sb.push_back(v);
      @(negedge clk);
      e   = sb.pop_front();
      got = sample();
      if (e.en_only) check(e.name, {12'd0, got[3:0]}, {12'd0, e.exp[3:0]});
      else           check(e.name, got, e.exp);
`ifdef ILLEGAL_TRAP_EN
      check({e.name, "_illegal"}, {15'd0, illegal_instr}, 16'd0);
`endif
      @(posedge clk);
      #1;
    end

    // lw with three stalled MEMREAD cycles; back in FETCH after 8 cycles.
    stall = 0; cycles = 0; rw_cnt = 0; adr_cnt = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      drive(LW, 3'b010, 0, 0, 1, 0);
      if (bus.adr_src && stall < 3) begin
        bus.mem_ready = 1'b0;
        stall++;
      end
      @(negedge clk);
      if (bus.ir_write && c > 0) begin
        done   = 1;
        cycles = c;
      end else begin
        if (bus.adr_src) adr_cnt++;
        if (bus.reg_write) begin
          rw_cnt++;
          check("lws_wb_src", {14'd0, bus.result_src}, 16'd1);
        end
        @(posedge clk);
        #1;
      end
    end
    check("lws_done", {15'd0, done}, 16'd1);
    check("lws_cycles", cycles[15:0], 16'd8);
    check("lws_regw", rw_cnt[15:0], 16'd1);
    check("lws_adr", adr_cnt[15:0], 16'd4);

    // Unsupported opcode, starting from the FETCH cycle left above.
    drive(BAD, 3'b000, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    got = sample();
    check("bad_dec", got, o(2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got = sample();
      check("trap_en", {12'd0, got[3:0]}, 16'd0);
      check("trap_flag", {15'd0, illegal_instr}, 16'd1);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    got = sample();
    check("trap_rst_en", {12'd0, got[3:0]}, 16'd0);
    check("trap_rst_flag", {15'd0, illegal_instr}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    got = sample();
    check("trap_exit", got, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
    check("trap_exit_flag", {15'd0, illegal_instr}, 16'd0);
`else
    @(negedge clk);
    got = sample();
    check("bad_nop", got, o(2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, 1, 1, 0, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I datapath: register file, single ALU, shared instruction/data memory port, immediate extender.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the immediate-format select (imm_src), ALU operand muxes, ALU operation, result mux and all write enables.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), addi-class I-type, beq/bne, jal.

Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = mem_ready ignored, single-cycle memory.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; state <= FETCH.
- op  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1 register.
- alu_src_b  out  2  00 rs2 register, 01 immediate, 10 constant 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- adr_src  out  1  0 = PC, 1 = result.
- ir_write, pc_write, reg_write, mem_write  out  1 each  write enables.

Behaviour:
- State register: 4 bits, updated on posedge clk.
- Outputs are combinational from the current state plus op/funct3/funct7b5/zero/mem_ready (Moore-style, with pc_write and handshake gating).
- While reset is high: ir_write, pc_write, reg_write and mem_write are forced to 0.
- First cycle after reset deasserts: state is FETCH.
- Unlisted outputs in any state are 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10.
  - ir_write = pc_write = mem_ready (or 1 when MEM_HANDSHAKE=0).
  - Next state: DECODE when ready, else stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (branch target computed into ALUOut).
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other op -> FETCH (NOP).
- MEMADR: alu_src_a=10, alu_src_b=01, aluop=00.
  - Next state: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 for every cycle in the state. Hold until ready, then -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, aluop=10. Next state -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, aluop=10. Next state -> ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq taken on zero=1, bne taken on zero=0).
  - Next state -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_write=1. Next state -> ALUWB (writes rd = PC+4).
- imm_src is decoded from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all other ops -> 00
- alu_control decode:
  - aluop 00 -> add.
  - aluop 01 -> sub.
  - aluop 10, funct3=000 -> sub if (op[5] & funct7b5), else add.
  - aluop 10, funct3=010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Unused state encodings: next state -> FETCH; all enables 0.
- Reset asserted mid-instruction (any state): the pending write is suppressed in that cycle; next state is FETCH.
- Instruction cycle counts with mem_ready=1: lw 5, sw 4, R/I 4, branch 3, jal 4.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal_instr (1 bit).
  - DECODE with an unsupported op -> TRAP state.
  - TRAP: all enables 0, illegal_instr=1; TRAP is sticky and is exited only by reset.
  - illegal_instr is 0 in every other state and during reset.
- Undefined: the port is absent; unsupported ops return to FETCH as a NOP.

Test Plan:
- reset high for 2 cycles, then low, mem_ready=1 -> cycle 0: ir_write=1, pc_write=1, alu_src_b=10; cycle 1: DECODE, all enables 0.
- lw (op=0000011), mem_ready=0 for 3 cycles in MEMREAD -> adr_src=1 held for 3 extra cycles; reg_write=1 with result_src=01 exactly once; total 8 cycles.
- sw (op=0100011) -> imm_src=01 throughout; mem_write=1 only in MEMWRITE; reg_write never asserted.
- beq (funct3=000): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0. bne (funct3=001) inverts both results. imm_src=10.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR. addi with funct7b5=1 -> alu_control=000. jal -> imm_src=11, pc_write in JAL, reg_write in ALUWB.
- op=1111111 -> returns to FETCH after DECODE with no enables (feature off). With ILLEGAL_TRAP_EN: illegal_instr=1, remains in TRAP for 10 cycles; reset clears to FETCH.
